// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, CPHA modes and default widths.
// Imported by the SCLK engine, the master FSM and the shifters.
package spi_pkg;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF = 6;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;

endpackage

// File: rtl/spi_half_period_counter.sv
// Runtime-divisor half-period counter for the SPI SCLK engine.
// Emits a terminal-count pulse one cycle ahead of each SCLK edge.
module spi_half_period_counter
  import spi_pkg::*;
#(
  parameter int W = DIV_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d_in,
  output logic         tc
);

  logic [W-1:0] d_q;
  logic [W-1:0] cnt_q;

  // The load cycle counts as position 0, so with D=1 the
  // first edge is already due from the load cycle itself.
  always_comb begin
    tc = 1'b0;
    if (clr) begin
      tc = 1'b0;
    end else if (load) begin
      tc = (d_in == W'(1));
    end else if (en) begin
      tc = (cnt_q == d_q - W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      d_q   <= d_in;
      cnt_q <= (d_in == W'(1)) ? '0 : W'(1);
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_generator.sv
// Programmable SPI SCLK engine: runtime divider, CPOL/CPHA,
// per-edge sample/shift strobes, start/busy/done and abort.
module spi_sclk_generator
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] div_half,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 cpol,
  input  logic                 cpha,
  output logic                 busy,
  output logic                 sclk,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sample_tick,
  output logic                 shift_tick,
  output logic                 done
);

  localparam int EW = LEN_WIDTH + 1;

  logic                 state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 cpol_q;
  logic                 cpha_q;
  logic [EW-1:0]        ecnt_q;

  logic                 in_run;
  logic                 accept;
  logic                 frame_end;
  logic                 run_go;
  logic                 tc;
  logic                 cpha_m;
  logic                 lead_d;
  logic                 trail_d;
  logic                 sample_d;
  logic                 shift_d;
  logic [DIV_WIDTH-1:0] d_eff;
  logic [EW-1:0]        k;
  logic [EW-1:0]        two_n;

  assign in_run = (state_q == ST_RUN);
  assign accept = !in_run && start && !abort
                  && (frame_len != '0);
  assign d_eff  = (div_half == '0) ? DIV_WIDTH'(1)
                                   : div_half;

  assign two_n     = {len_q, 1'b0};
  assign frame_end = in_run && (ecnt_q == two_n);
  assign run_go    = in_run && !abort && !frame_end;

  spi_half_period_counter #(
    .W (DIV_WIDTH)
  ) u_half (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_go),
    .clr   (in_run && !run_go),
    .load  (accept),
    .d_in  (d_eff),
    .tc    (tc)
  );

  // ecnt_q is 0 throughout IDLE, so k=1 in the accept cycle.
  assign k      = ecnt_q + EW'(1);
  assign cpha_m = accept ? cpha : cpha_q;

  assign lead_d  = tc && k[0];
  assign trail_d = tc && !k[0];

  always_comb begin
    sample_d = 1'b0;
    shift_d  = 1'b0;
    if (cpha_m == CPHA_LEAD) begin
      sample_d = lead_d;
      shift_d  = trail_d && (k != two_n);
    end else begin
      sample_d = trail_d;
      shift_d  = lead_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      ecnt_q      <= '0;
      busy        <= 1'b0;
      sclk        <= 1'b0;
      lead_edge   <= 1'b0;
      trail_edge  <= 1'b0;
      sample_tick <= 1'b0;
      shift_tick  <= 1'b0;
      done        <= 1'b0;
    end else begin
      lead_edge   <= lead_d;
      trail_edge  <= trail_d;
      sample_tick <= sample_d;
      shift_tick  <= shift_d;
      done        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sclk <= tc ? ~cpol : cpol;
          if (accept) begin
            state_q <= ST_RUN;
            busy    <= 1'b1;
            len_q   <= frame_len;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            ecnt_q  <= tc ? EW'(1) : '0;
          end
        end
        default: begin
          if (!run_go) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            sclk    <= cpol_q;
            ecnt_q  <= '0;
            done    <= frame_end && !abort;
          end else if (tc) begin
            sclk   <= ~sclk;
            ecnt_q <= k;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_generator.sv
// Bench for spi_sclk_generator: directed scenarios plus random
// stimulus against a per-cycle arithmetic frame model.
module tb_spi_sclk_generator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] div_half;
  logic [5:0] frame_len;
  logic       cpol;
  logic       cpha;
  logic       busy;
  logic       sclk;
  logic       lead_edge;
  logic       trail_edge;
  logic       sample_tick;
  logic       shift_tick;
  logic       done;

  spi_sclk_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .div_half    (div_half),
    .frame_len   (frame_len),
    .cpol        (cpol),
    .cpha        (cpha),
    .busy        (busy),
    .sclk        (sclk),
    .lead_edge   (lead_edge),
    .trail_edge  (trail_edge),
    .sample_tick (sample_tick),
    .shift_tick  (shift_tick),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_samp = 0;
  int n_shift = 0;

  // model state: one active frame described by its start-relative cycle
  bit m_act;
  int m_rel, m_D, m_N;
  bit m_cpol, m_cpha;
  bit e_busy, e_sclk, e_lead, e_trail, e_samp, e_shift, e_done;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs();
    check("busy",   32'(busy),        32'(e_busy));
    check("sclk",   32'(sclk),        32'(e_sclk));
    check("lead",   32'(lead_edge),   32'(e_lead));
    check("trail",  32'(trail_edge),  32'(e_trail));
    check("sample", 32'(sample_tick), 32'(e_samp));
    check("shift",  32'(shift_tick),  32'(e_shift));
    check("done",   32'(done),        32'(e_done));
  endtask

  task automatic clear_exp(input bit lvl);
    e_busy = 0; e_sclk = lvl; e_lead = 0; e_trail = 0;
    e_samp = 0; e_shift = 0; e_done = 0;
  endtask

  // outputs in cycle r of a frame: edge k lands at cycle k*D
  task automatic frame_at(input int r);
    int  k;
    bit  edge_now;
    k        = r / m_D;
    edge_now = (r % m_D) == 0;
    clear_exp(m_cpol ^ bit'(k % 2));
    e_busy  = 1;
    e_lead  = edge_now && (k % 2 == 1);
    e_trail = edge_now && (k % 2 == 0);
    if (!m_cpha) begin
      e_samp  = e_lead;
      e_shift = e_trail && (k != 2 * m_N);
    end else begin
      e_samp  = e_trail;
      e_shift = e_lead;
    end
  endtask

  task automatic step(input bit s, a, input int dh, fl,
                      input bit cp, ch);
    if (m_act && a) begin
      m_act = 0;
      clear_exp(m_cpol);
    end else if (m_act && m_rel == 2 * m_D * m_N) begin
      m_act = 0;
      clear_exp(m_cpol);
      e_done = 1;
    end else if (m_act) begin
      m_rel++;
      frame_at(m_rel);
    end else if (s && !a && fl != 0) begin
      m_act  = 1;
      m_rel  = 1;
      m_D    = (dh == 0) ? 1 : dh;
      m_N    = fl;
      m_cpol = cp;
      m_cpha = ch;
      frame_at(1);
    end else begin
      clear_exp(cp);
    end
  endtask

  task automatic tick(input bit s, a, input int dh, fl,
                      input bit cp, ch);
    check_outs();
    n_samp  += int'(sample_tick);
    n_shift += int'(shift_tick);
    start     = s;
    abort     = a;
    div_half  = 8'(dh);
    frame_len = 6'(fl);
    cpol      = cp;
    cpha      = ch;
    step(s, a, dh, fl, cp, ch);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input bit cp);
    repeat (n) tick(0, 0, 0, 0, cp, 0);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; div_half = 0;
    frame_len = 0; cpol = 0; cpha = 0;
    m_act = 0;
    clear_exp(0);
    @(negedge clk);
    idle(2, 0);
    rst_n = 1;
    idle(3, 0);

    // mode 0, D=2, N=8
    n_samp = 0; n_shift = 0;
    tick(1, 0, 2, 8, 0, 0);
    idle(40, 0);
    check("m0_sample_count", 32'(n_samp), 32'd8);
    check("m0_shift_count", 32'(n_shift), 32'd7);

    // mode 3, D=1, N=4
    idle(3, 1);
    n_samp = 0; n_shift = 0;
    tick(1, 0, 1, 4, 1, 1);
    idle(12, 1);
    check("m3_sample_count", 32'(n_samp), 32'd4);
    check("m3_shift_count", 32'(n_shift), 32'd4);

    // div_half=0 behaves as 1, then frame_len=0 is ignored
    idle(2, 0);
    tick(1, 0, 0, 1, 0, 0);
    idle(5, 0);
    tick(1, 0, 3, 0, 0, 0);
    idle(4, 0);

    // abort at cycle 5, restart at cycle 7
    tick(1, 0, 3, 8, 0, 0);
    idle(4, 0);
    tick(0, 1, 3, 8, 0, 0);
    idle(1, 0);
    tick(1, 0, 3, 8, 0, 0);
    idle(55, 0);

    // start held high with config churn: ignored while busy,
    // back-to-back accept in every done cycle
    repeat (120)
      tick(1, 0, $urandom_range(0, 3), $urandom_range(1, 5),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    idle(30, 0);

    // async reset at cycle 10 of a mode-2 frame
    idle(2, 1);
    tick(1, 0, 2, 8, 1, 0);
    idle(9, 1);
    check_outs();
    #2 rst_n = 0;
    #1;
    m_act = 0;
    clear_exp(0);
    check_outs();
    @(negedge clk);
    cyc++;
    rst_n = 1;
    idle(3, 1);

    // random traffic
    repeat (2500)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 4), $urandom_range(0, 6),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    idle(80, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_generator.md
Name: spi_sclk_generator

Overview:
Programmable SPI serial-clock engine, successor to the fixed-ratio SPI clock divider. It generates SCLK for a complete frame of N bits with a runtime divider, CPOL/CPHA mode support, and per-edge sample/shift strobes. It sits between the SPI master control FSM and the shift registers, and frames transfers with a start/busy/done handshake and an abort path.

Parameters:
DIV_WIDTH, 8, width of the runtime half-period divider input
LEN_WIDTH, 6, width of the frame-length input (max frame 2^LEN_WIDTH-1 bits)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  frame request; accepted only in IDLE
abort  input  1  terminate the current frame immediately
div_half  input  DIV_WIDTH  SCLK half-period in clk cycles; 0 is treated as 1
frame_len  input  LEN_WIDTH  bits per frame; 0 means start is ignored
cpol  input  1  SCLK idle level
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge
busy  output  1  frame in progress
sclk  output  1  serial clock
lead_edge  output  1  1-cycle pulse on each leading (idle-to-active) SCLK edge
trail_edge  output  1  1-cycle pulse on each trailing SCLK edge
sample_tick  output  1  1-cycle pulse: capture MISO now
shift_tick  output  1  1-cycle pulse: drive next MOSI bit now
done  output  1  1-cycle pulse at normal frame completion

Behaviour:
- All outputs are registered. Reset values: busy=0, sclk=0, all pulse outputs=0. Internal state: IDLE, counters=0.
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- FSM states: IDLE, RUN.
- IDLE:
  - sclk <= cpol each cycle, so sclk follows cpol with 1-cycle latency.
  - If start=1, abort=0 and frame_len!=0, then in the same cycle: latch div_half (0 becomes 1), frame_len, cpol and cpha; clear the counters; go to RUN.
- Timing, with start sampled in cycle 0:
  - busy=1 from cycle 1.
  - The half-period counter runs 0..D-1, where D is the latched divider. At terminal count it wraps to 0, toggles sclk and pulses one edge strobe.
  - Edge k (k=1..2N) is visible in cycle k*D. sclk and the strobe change in the same cycle.
  - Odd k = lead_edge; even k = trail_edge.
- Strobes:
  - cpha=0: sample_tick on every lead_edge. shift_tick on every trail_edge except edge 2N.
  - cpha=1: shift_tick on every lead_edge. sample_tick on every trail_edge.
  - At most one edge strobe per cycle.
- Completion: the cycle after edge 2N, done=1 for one cycle, busy=0, state returns to IDLE, and sclk equals the latched cpol.
- Config inputs change while busy: ignored; the latched values are used.
- start while busy: ignored, no queuing.
- abort in RUN:
  - Next cycle: busy=0, sclk=latched cpol, all strobes 0, done never asserted for that frame, state IDLE.
  - abort and a terminal count in the same cycle: abort wins, no strobe.
- abort in IDLE: no effect. If start and abort are both 1 in IDLE, start is ignored.
- Reset mid-frame: immediate return to reset values.
- Minimum operating point: D=1 gives sclk = clk/2 with an edge every cycle, and must work.
- Counter widths: the half-period counter is DIV_WIDTH bits. The edge counter is LEN_WIDTH+1 bits (counts to 2N). No overflow is possible.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE/RUN).
  - CPHA mode constants.
  - Default DIV_WIDTH and LEN_WIDTH localparams, shared with the master FSM and shifter.
- One sub-module: spi_half_period_counter.
  - Enable, sync clear and load of D.
  - Terminal-count pulse.
  - Generalises the old divider to a runtime divider.
- Edge counting, mode decode and FSM stay in the top module.

Test Plan:
- Mode 0 (cpol=0, cpha=0), D=2, N=8, start at cycle 0:
  - 16 edges at cycles 2,4,...,32.
  - 8 sample_ticks on rising edges; 7 shift_ticks.
  - done at cycle 33; busy high for cycles 1-32.
- Mode 3 (cpol=1, cpha=1), D=1, N=4:
  - sclk idles 1; edges every cycle, cycles 1-8.
  - shift_tick on falling edges (1,3,5,7); sample_tick on rising edges (2,4,6,8).
  - done at cycle 9 with sclk=1.
- div_half=0, N=1:
  - Behaves as D=1: edges at cycles 1 and 2, done at cycle 3.
  - frame_len=0 with start: busy stays 0, no pulses.
- abort at cycle 5 of a D=3, N=8 frame:
  - busy=0 and sclk=cpol at cycle 6; no done; no further strobes.
  - A new start at cycle 7 runs a full frame normally.
- Start while busy, and cpol/div_half toggled mid-frame:
  - No effect on the running frame's timing or level.
  - Back-to-back start in the done cycle is accepted; second frame busy from the next cycle.
- rst_n asserted asynchronously mid-frame (cycle 10, mode 2):
  - All outputs 0 immediately.
  - After release, sclk=1 one cycle later (cpol tracking in IDLE).
